// File: rtl/apb_uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
//   MAX_DATA_BITS : width of the data word ports (frames of 5..10 data bits)
//   MIN_DIV       : smallest clk-per-bit divisor honoured; smaller requests are raised to it
//   uart_state_e  : frame state encoding
//   clamp_div     : applies the MIN_DIV floor to a requested divisor
package apb_uart_pkg;

   localparam int unsigned MAX_DATA_BITS = 10;
   localparam int unsigned MIN_DIV       = 4;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } uart_state_e;

   function automatic logic [15:0] clamp_div(input logic [15:0] div);
      return (div < 16'(MIN_DIV)) ? 16'(MIN_DIV) : div;
   endfunction

endpackage

// File: rtl/apb_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
//   clk : sampling clock
//   rst : synchronous active-high reset; both flops go to 1 (line idle)
//   d   : asynchronous input
//   q   : synchronized output, two cycles behind d
module apb_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/apb_rx.sv
// UART receiver: one start bit, DATA_BITS data bits (LSB first), one stop bit.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   rx_in     : asynchronous serial line, idle high
//   baud_div  : clk cycles per bit period, sampled at frame start, floored at MIN_DIV
//   rx_ack    : consumer acknowledge of the held word
//   dout      : last good word, upper unused bits zero
//   rx_valid  : dout holds unacknowledged data
//   frame_err : one-cycle pulse when a stop bit is sampled low
//   overrun   : one-cycle pulse when a good frame replaces unacknowledged data
//   busy      : receiver is not idle
module apb_rx
   import apb_uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_in,
   input  logic [15:0]              baud_div,
   input  logic                     rx_ack,
   output logic [MAX_DATA_BITS-1:0] dout,
   output logic                     rx_valid,
   output logic                     frame_err,
   output logic                     overrun,
   output logic                     busy
);

   logic rxs;

   apb_rx_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_in),
      .q   (rxs)
   );

   uart_state_e              state_q, state_d;
   logic [15:0]              div_q, div_d;
   logic [15:0]              cnt_q, cnt_d;
   logic [3:0]               idx_q, idx_d;
   logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
   logic [MAX_DATA_BITS-1:0] dout_q, dout_d;
   logic                     valid_q, valid_d;
   logic                     ferr_q, ferr_d;
   logic                     ovr_q, ovr_d;

   logic        tick;
   logic [15:0] div_new;

   assign tick    = (cnt_q == 16'd0);
   assign div_new = clamp_div(baud_div);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      dout_d  = dout_q;
      valid_d = valid_q;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      if (rx_ack && valid_q) begin
         valid_d = 1'b0;
      end

      // Bit timer runs only while a frame is being sampled.
      if (state_q == StStart || state_q == StData || state_q == StStop) begin
         cnt_d = tick ? (div_q - 16'd1) : (cnt_q - 16'd1);
      end

      case (state_q)
         StIdle: begin
            if (!rxs) begin
               state_d = StStart;
               div_d   = div_new;
               // First tick lands mid-way through the start bit.
               cnt_d   = (div_new >> 1) - 16'd1;
               shreg_d = '0;
            end
         end
         StStart: begin
            if (tick) begin
               if (!rxs) begin
                  state_d = StData;
                  idx_d   = 4'd0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (tick) begin
               shreg_d[idx_q] = rxs;
               if (idx_q == 4'(DATA_BITS - 1)) begin
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         StStop: begin
            if (tick) begin
               if (rxs) begin
                  dout_d  = shreg_q;
                  valid_d = 1'b1;
                  // A same-cycle ack consumes the old word, so nothing is lost.
                  ovr_d   = valid_q && !rx_ack;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StWaitHigh;
               end
            end
         end
         StWaitHigh: begin
            // Hold off until the line recovers so a break is not read as a new start bit.
            if (rxs) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         div_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign dout      = dout_q;
   assign rx_valid  = valid_q;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_apb_rx.sv
// Directed bench for apb_rx: an 8-bit instance (a) and a 10-bit instance (b) share
// one driven line; use10 steers the line to one instance while the other sees idle.
module tb_apb_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_line;
   logic        use10;
   logic        rx_ack;
   logic [15:0] baud_div;
   logic        rx_a, rx_b;

   logic [9:0] dout_a, dout_b;
   logic       rx_valid_a, rx_valid_b;
   logic       frame_err_a, frame_err_b;
   logic       overrun_a, overrun_b;
   logic       busy_a, busy_b;

   int vec_cnt = 0;
   int err_cnt = 0;
   int ferr_cnt = 0;
   int ovr_cnt = 0;
   int ferr_b_cnt = 0;
   int valid_rise_n;

   always #5 clk = ~clk;

   assign rx_a = use10 ? 1'b1 : rx_line;
   assign rx_b = use10 ? rx_line : 1'b1;

   apb_rx #(.DATA_BITS(8)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_a),
      .baud_div  (baud_div),
      .rx_ack    (rx_ack),
      .dout      (dout_a),
      .rx_valid  (rx_valid_a),
      .frame_err (frame_err_a),
      .overrun   (overrun_a),
      .busy      (busy_a)
   );

   apb_rx #(.DATA_BITS(10)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .rx_in     (rx_b),
      .baud_div  (baud_div),
      .rx_ack    (rx_ack),
      .dout      (dout_b),
      .rx_valid  (rx_valid_b),
      .frame_err (frame_err_b),
      .overrun   (overrun_b),
      .busy      (busy_b)
   );

   // Pulse monitors: count high cycles of the one-cycle outputs.
   always @(posedge clk) begin
      if (frame_err_a) ferr_cnt++;
      if (overrun_a) ovr_cnt++;
      if (frame_err_b) ferr_b_cnt++;
   end

   // Drives one frame starting at the current negedge. ack_at / rst_at give the
   // negedge index (0 = start bit) at which rx_ack or rst is pulsed; -1 disables.
   task automatic send_frame(input logic [9:0] data, input int nbits, input logic stop_bit,
                             input int bitlen, input int tail_len, input logic tail_level,
                             input int ack_at, input int rst_at);
      int   total;
      int   b;
      logic lvl;
      logic v;
      logic prev_v;
      total        = (nbits + 2) * bitlen + tail_len;
      valid_rise_n = -1;
      prev_v       = use10 ? rx_valid_b : rx_valid_a;
      for (int n = 0; n < total; n++) begin
         v = use10 ? rx_valid_b : rx_valid_a;
         if (!prev_v && v && valid_rise_n < 0) valid_rise_n = n;
         prev_v = v;
         b = n / bitlen;
         if (b == 0) lvl = 1'b0;
         else if (b <= nbits) lvl = data[b-1];
         else if (b == nbits + 1) lvl = stop_bit;
         else lvl = tail_level;
         rx_line = lvl;
         rx_ack  = (n == ack_at);
         if (n == rst_at) begin
            rst     = 1'b1;
            rx_line = 1'b1;
            rx_ack  = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
      end
      rx_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      rx_line  = 1'b1;
      use10    = 1'b0;
      rx_ack   = 1'b0;
      baud_div = 16'd16;
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (dout_a !== 10'h000) begin
         err_cnt++; $display("FAIL reset_dout: got %h want 000", dout_a);
      end
      vec_cnt++;
      if ({rx_valid_a, frame_err_a, overrun_a, busy_a} !== 4'b0000) begin
         err_cnt++;
         $display("FAIL reset_flags: got %b want 0000",
                  {rx_valid_a, frame_err_a, overrun_a, busy_a});
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_frame();
      send_frame(10'h0A5, 8, 1'b1, 16, 8, 1'b1, -1, -1);
      vec_cnt++;
      if (dout_a !== 10'h0A5) begin
         err_cnt++; $display("FAIL good_dout: got %h want 0a5", dout_a);
      end
      vec_cnt++;
      if (rx_valid_a !== 1'b1) begin
         err_cnt++; $display("FAIL good_valid: got %b want 1", rx_valid_a);
      end
      // 3 cycles to START, 8 to mid start bit, 9 bit periods to the stop sample.
      vec_cnt++;
      if (valid_rise_n != 155) begin
         err_cnt++; $display("FAIL good_latency: got %0d want 155", valid_rise_n);
      end
      vec_cnt++;
      if (ferr_cnt != 0 || ovr_cnt != 0) begin
         err_cnt++; $display("FAIL good_pulses: got ferr=%0d ovr=%0d want 0 0", ferr_cnt, ovr_cnt);
      end
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      vec_cnt++;
      if (rx_valid_a !== 1'b0 || dout_a !== 10'h0A5) begin
         err_cnt++; $display("FAIL ack_clear: got v=%b d=%h want v=0 d=0a5", rx_valid_a, dout_a);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_glitch();
      int f0, o0;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      rx_line = 1'b0;
      repeat (4) @(negedge clk);
      rx_line = 1'b1;
      vec_cnt++;
      if (busy_a !== 1'b1) begin
         err_cnt++; $display("FAIL glitch_start: got busy=%b want 1", busy_a);
      end
      repeat (20) @(negedge clk);
      vec_cnt++;
      if (busy_a !== 1'b0 || rx_valid_a !== 1'b0 || dout_a !== 10'h0A5) begin
         err_cnt++;
         $display("FAIL glitch_idle: got busy=%b v=%b d=%h want 0 0 0a5", busy_a, rx_valid_a, dout_a);
      end
      vec_cnt++;
      if (ferr_cnt != f0 || ovr_cnt != o0) begin
         err_cnt++; $display("FAIL glitch_pulses: got ferr=%0d ovr=%0d want %0d %0d",
                             ferr_cnt, ovr_cnt, f0, o0);
      end
   endtask

   task automatic test_frame_error();
      int f0;
      f0 = ferr_cnt;
      send_frame(10'h03C, 8, 1'b0, 16, 48, 1'b0, -1, -1);
      vec_cnt++;
      if (ferr_cnt != f0 + 1) begin
         err_cnt++; $display("FAIL ferr_pulse: got %0d want %0d", ferr_cnt - f0, 1);
      end
      vec_cnt++;
      if (rx_valid_a !== 1'b0 || dout_a !== 10'h0A5) begin
         err_cnt++; $display("FAIL ferr_hold: got v=%b d=%h want 0 0a5", rx_valid_a, dout_a);
      end
      vec_cnt++;
      if (busy_a !== 1'b1) begin
         err_cnt++; $display("FAIL ferr_wait_high: got busy=%b want 1", busy_a);
      end
      rx_line = 1'b1;
      repeat (8) @(negedge clk);
      vec_cnt++;
      if (busy_a !== 1'b0 || ferr_cnt != f0 + 1 || rx_valid_a !== 1'b0) begin
         err_cnt++; $display("FAIL ferr_recover: got busy=%b ferr=%0d v=%b want 0 1 0",
                             busy_a, ferr_cnt - f0, rx_valid_a);
      end
   endtask

   task automatic test_overrun();
      int o0;
      o0 = ovr_cnt;
      send_frame(10'h011, 8, 1'b1, 16, 8, 1'b1, -1, -1);
      vec_cnt++;
      if (dout_a !== 10'h011 || rx_valid_a !== 1'b1) begin
         err_cnt++; $display("FAIL ovr_first: got d=%h v=%b want 011 1", dout_a, rx_valid_a);
      end
      send_frame(10'h022, 8, 1'b1, 16, 8, 1'b1, -1, -1);
      vec_cnt++;
      if (dout_a !== 10'h022 || rx_valid_a !== 1'b1) begin
         err_cnt++; $display("FAIL ovr_second: got d=%h v=%b want 022 1", dout_a, rx_valid_a);
      end
      vec_cnt++;
      if (ovr_cnt != o0 + 1) begin
         err_cnt++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - o0);
      end
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      vec_cnt++;
      if (rx_valid_a !== 1'b0) begin
         err_cnt++; $display("FAIL ovr_ack: got v=%b want 0", rx_valid_a);
      end
      o0 = ovr_cnt;
      send_frame(10'h011, 8, 1'b1, 16, 8, 1'b1, -1, -1);
      // Ack lands on the stop-bit sample edge (negedge 154 -> posedge 155).
      send_frame(10'h022, 8, 1'b1, 16, 8, 1'b1, 154, -1);
      vec_cnt++;
      if (dout_a !== 10'h022 || rx_valid_a !== 1'b1) begin
         err_cnt++; $display("FAIL ack_same_cycle: got d=%h v=%b want 022 1", dout_a, rx_valid_a);
      end
      vec_cnt++;
      if (ovr_cnt != o0) begin
         err_cnt++; $display("FAIL ack_same_cycle_ovr: got %0d want 0", ovr_cnt - o0);
      end
   endtask

   task automatic test_ten_bits();
      use10    = 1'b1;
      baud_div = 16'd2;
      // Divisor is floored to 4, so bits last 4 clocks.
      send_frame(10'h2B7, 10, 1'b1, 4, 8, 1'b1, -1, -1);
      vec_cnt++;
      if (dout_b !== 10'h2B7 || rx_valid_b !== 1'b1) begin
         err_cnt++; $display("FAIL ten_bits: got d=%h v=%b want 2b7 1", dout_b, rx_valid_b);
      end
      vec_cnt++;
      if (ferr_b_cnt != 0 || dout_a !== 10'h022) begin
         err_cnt++; $display("FAIL ten_bits_side: got ferr_b=%0d d_a=%h want 0 022",
                             ferr_b_cnt, dout_a);
      end
      use10    = 1'b0;
      baud_div = 16'd16;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int f0, o0;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      // Negedge 65 falls while data index 3 is being timed.
      send_frame(10'h0FF, 8, 1'b1, 16, 8, 1'b1, -1, 65);
      vec_cnt++;
      if (dout_a !== 10'h000 || dout_b !== 10'h000) begin
         err_cnt++; $display("FAIL rst_mid_dout: got a=%h b=%h want 000 000", dout_a, dout_b);
      end
      vec_cnt++;
      if ({rx_valid_a, frame_err_a, overrun_a, busy_a} !== 4'b0000) begin
         err_cnt++;
         $display("FAIL rst_mid_flags: got %b want 0000",
                  {rx_valid_a, frame_err_a, overrun_a, busy_a});
      end
      repeat (4) @(negedge clk);
      send_frame(10'h05A, 8, 1'b1, 16, 8, 1'b1, -1, -1);
      vec_cnt++;
      if (dout_a !== 10'h05A || rx_valid_a !== 1'b1) begin
         err_cnt++; $display("FAIL rst_then_frame: got d=%h v=%b want 05a 1", dout_a, rx_valid_a);
      end
      vec_cnt++;
      if (ferr_cnt != f0 || ovr_cnt != o0) begin
         err_cnt++; $display("FAIL rst_pulses: got ferr=%0d ovr=%0d want 0 0",
                             ferr_cnt - f0, ovr_cnt - o0);
      end
   endtask

   initial begin
      rst      = 1'b1;
      rx_line  = 1'b1;
      use10    = 1'b0;
      rx_ack   = 1'b0;
      baud_div = 16'd16;
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_ten_bits();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/apb_rx.md
APB_RX -- requirements
Module: apb_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, number of data bits per frame, legal range 5..10.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have port rx_in, input, 1, the asynchronous serial line, idle high.
REQ-005 The block SHALL have port baud_div, input, 16, the clk cycles per bit period.
REQ-006 The block SHALL have port rx_ack, input, 1, the consumer acknowledge of held data.
REQ-007 The block SHALL have port dout, output, 10, the received word, LSB = first data bit, bits >= DATA_BITS zero.
REQ-008 The block SHALL have port rx_valid, output, 1, which is high while dout holds unacknowledged data.
REQ-009 The block SHALL have port frame_err, output, 1, a one-cycle pulse when the stop bit is sampled low.
REQ-010 The block SHALL have port overrun, output, 1, a one-cycle pulse when a good frame completes while rx_valid is still high.
REQ-011 The block SHALL have port busy, output, 1, which is high in every state except IDLE.

Function
REQ-012 rx_in SHALL pass a 2-flop synchronizer; all decisions use the synchronized value rxs (2-cycle latency).
REQ-013 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE SHALL go to START on the first cycle rxs=0, latching div = max(baud_div,4) for the whole frame and loading the bit counter with div/2-1 (integer divide).
REQ-015 The bit counter SHALL count down once per cycle; "tick" is the cycle it equals 0, and on tick it reloads div-1.
REQ-016 On tick in START: rxs=0 SHALL go to DATA with data index 0; rxs=1 SHALL be treated as a glitch and return to IDLE with no output change.
REQ-017 On tick in DATA: rxs SHALL shift into the shift register at the current index (LSB first); after index DATA_BITS-1 the state goes to STOP, otherwise the index increments.
REQ-018 On tick in STOP with rxs=1: dout SHALL load the shift register, rx_valid SHALL be 1 from the next cycle, and the state returns to IDLE.
REQ-019 On tick in STOP with rxs=0: frame_err SHALL pulse for one cycle, dout and rx_valid SHALL be unchanged, and the state goes to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL go to IDLE on the first cycle rxs=1, so that break conditions do not retrigger.
REQ-021 rx_ack with rx_valid=1 SHALL clear rx_valid on the next cycle; rx_ack with rx_valid=0 SHALL be ignored.
REQ-022 If a good-frame completion and rx_ack occur in the same cycle, rx_valid SHALL stay 1 with the new dout and overrun SHALL not pulse.
REQ-023 A good frame completing with rx_valid=1 and no rx_ack SHALL overwrite dout, keep rx_valid=1, and pulse overrun.
REQ-024 Changes to baud_div mid-frame SHALL have no effect until the next START entry.

Reset
REQ-025 While rst=1 at a clk edge, the state SHALL go to IDLE; the counters and shift register SHALL clear; dout=0, rx_valid=0, frame_err=0, overrun=0 and busy=0; both synchronizer flops SHALL be set to 1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no frame_err or overrun pulse; reception restarts on the next falling edge after rst=0.

Structure
REQ-027 A shared package apb_uart_pkg SHALL hold the state encoding, MAX_DATA_BITS=10 and MIN_DIV=4, and is usable by the TX side.
REQ-028 The synchronizer SHALL be one sub-module, apb_rx_sync (2 flops, reset value 1); everything else SHALL be in apb_rx.

Verification
REQ-029 Case 1: baud_div=16, DATA_BITS=8, frame 0xA5 with a good stop bit -> dout=0x0A5 and rx_valid=1, starting about 9.5 bit periods after the falling edge; frame_err=0.
REQ-030 Case 2: rx_in low for 4 cycles then high, baud_div=16 -> START then IDLE, rx_valid stays 0, and no pulses.
REQ-031 Case 3: frame 0x3C with stop bit 0, then line held low for 3 bit periods -> one frame_err pulse, rx_valid unchanged, and no new frame until rx_in returns high.
REQ-032 Case 4: frames 0x11 then 0x22 with no rx_ack -> dout=0x022 with one overrun pulse; repeat with rx_ack on the 0x22 completion cycle -> rx_valid=1 and no overrun.
REQ-033 Case 5: DATA_BITS=10, frame 0x2B7, baud_div=2 (clamped to 4) -> dout=0x2B7.
REQ-034 Case 6: rst pulsed during DATA index 3 -> all outputs 0 the next cycle; a following 0x5A frame is received correctly.
